// File: rtl/h_sync_decoder.sv
// Horizontal sync timing recovery: measures sync width and line period,
// locks after LOCK_LINES good lines and regenerates h_active/end_line/x_pos.
module h_sync_decoder #(
    parameter int unsigned H_FRONT_PORCH = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BACK_PORCH  = 48,
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned LOCK_LINES    = 2
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       enable,
    input  logic       h_sync_in,
    output logic       locked,
    output logic       h_active,
    output logic       end_line,
    output logic [9:0] x_pos,
    output logic       sync_err
);

    localparam int unsigned POS_W     = 10;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned H_TOTAL   = H_FRONT_PORCH + H_SYNC + H_BACK_PORCH + H_ACTIVE;
    localparam int unsigned ACT_START = H_SYNC + H_BACK_PORCH;
    localparam int unsigned ACT_END   = ACT_START + H_ACTIVE - 1;

    localparam logic [POS_W-1:0] POS_MAX     = '1;
    localparam logic [POS_W-1:0] POS_PRE_MAX = POS_W'((1 << POS_W) - 2);
    localparam logic [POS_W-1:0] WIDTH_LAST  = POS_W'(H_SYNC - 1);
    localparam logic [POS_W-1:0] PERIOD_LAST = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] ACT_START_P = POS_W'(ACT_START);
    localparam logic [POS_W-1:0] ACT_END_P   = POS_W'(ACT_END);
    localparam logic [CNT_W-1:0] LOCK_CNT    = CNT_W'(LOCK_LINES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             r_state;
    logic [POS_W-1:0]   r_pos;
    logic               r_sync_q;
    logic [CNT_W-1:0]   r_good_cnt;
    logic               r_width_ok;
    logic               r_locked;
    logic               r_h_active;
    logic               r_end_line;
    logic [POS_W-1:0]   r_x_pos;
    logic               r_sync_err;

    state_t             w_state_next;
    logic [POS_W-1:0]   w_pos_next;
    logic [CNT_W-1:0]   w_good_next;
    logic               w_width_ok_next;
    logic               w_err;
    logic               w_fall;
    logic               w_rise;
    logic               w_width_pass;
    logic               w_period_pass;
    logic               w_timeout;
    logic               w_in_win;
    logic               w_locked_next;

    assign w_fall        = r_sync_q & ~h_sync_in;
    assign w_rise        = ~r_sync_q & h_sync_in;
    assign w_width_pass  = (r_pos == WIDTH_LAST);
    assign w_period_pass = (r_pos == PERIOD_LAST) && r_width_ok;
    // Timeout fires only on the transition into saturation, and a fall wins.
    assign w_timeout     = !w_fall && (r_pos == POS_PRE_MAX);
    assign w_pos_next    = w_fall ? '0 : ((r_pos == POS_MAX) ? r_pos : r_pos + POS_W'(1));

    // Next-state, lock counter and error pulse
    always_comb begin
        w_state_next    = r_state;
        w_good_next     = r_good_cnt;
        w_width_ok_next = r_width_ok;
        w_err           = 1'b0;
        if (w_rise) begin
            w_width_ok_next = w_width_pass;
        end
        case (r_state)
            SEARCH: begin
                if (w_fall) begin
                    w_state_next    = CHECK;
                    w_good_next     = '0;
                    w_width_ok_next = 1'b0;
                end
            end
            CHECK: begin
                if (w_fall) begin
                    if (w_period_pass) begin
                        w_good_next = r_good_cnt + CNT_W'(1);
                        if (w_good_next == LOCK_CNT) begin
                            w_state_next = LOCKED;
                        end
                    end else begin
                        w_err       = 1'b1;
                        w_good_next = '0;
                    end
                end else if (w_rise && !w_width_pass) begin
                    w_err       = 1'b1;
                    w_good_next = '0;
                end
            end
            LOCKED: begin
                if ((w_fall && !w_period_pass) || (w_rise && !w_width_pass)) begin
                    w_err        = 1'b1;
                    w_state_next = CHECK;
                    w_good_next  = '0;
                end
            end
            default: begin
                w_state_next = SEARCH;
                w_good_next  = '0;
            end
        endcase
        if ((r_state == CHECK || r_state == LOCKED) && w_timeout) begin
            w_err        = 1'b1;
            w_state_next = SEARCH;
            w_good_next  = '0;
        end
    end

    assign w_locked_next = (w_state_next == LOCKED);
    assign w_in_win      = (w_pos_next >= ACT_START_P) && (w_pos_next <= ACT_END_P);

    // All state and outputs freeze while enable is low
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state    <= SEARCH;
            r_pos      <= '0;
            r_sync_q   <= 1'b1;
            r_good_cnt <= '0;
            r_width_ok <= 1'b0;
            r_locked   <= 1'b0;
            r_h_active <= 1'b0;
            r_end_line <= 1'b0;
            r_x_pos    <= '0;
            r_sync_err <= 1'b0;
        end else if (enable) begin
            r_state    <= w_state_next;
            r_pos      <= w_pos_next;
            r_sync_q   <= h_sync_in;
            r_good_cnt <= w_good_next;
            r_width_ok <= w_width_ok_next;
            r_locked   <= w_locked_next;
            r_h_active <= w_locked_next && w_in_win;
            r_end_line <= w_locked_next && (w_pos_next == ACT_END_P);
            r_x_pos    <= (w_locked_next && w_in_win) ? (w_pos_next - ACT_START_P) : '0;
            r_sync_err <= w_err;
        end
    end

    assign locked   = r_locked;
    assign h_active = r_h_active;
    assign end_line = r_end_line;
    assign x_pos    = r_x_pos;
    assign sync_err = r_sync_err;

endmodule

// File: tb/tb_h_sync_decoder.sv
// Directed bench for h_sync_decoder: lock acquisition, width/period/timeout
// violations, enable freeze and asynchronous reset mid-line.
module tb_h_sync_decoder;

    logic       clk;
    logic       rst_;
    logic       enable;
    logic       h_sync_in;
    logic       locked;
    logic       h_active;
    logic       end_line;
    logic [9:0] x_pos;
    logic       sync_err;

    int nchecks = 0;
    int nfail   = 0;

    // Per-line statistics gathered by drive_line
    int   act_cnt, end_cnt, err_cnt, err_pos, xbad;
    logic lock_first, lock_last;

    h_sync_decoder dut (
        .clk       (clk),
        .rst_      (rst_),
        .enable    (enable),
        .h_sync_in (h_sync_in),
        .locked    (locked),
        .h_active  (h_active),
        .end_line  (end_line),
        .x_pos     (x_pos),
        .sync_err  (sync_err)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One line of `len` cycles with the first `low` samples low; index i equals pos after its edge.
    task automatic drive_line(input int len, input int low);
        act_cnt = 0; end_cnt = 0; err_cnt = 0; err_pos = -1; xbad = 0;
        lock_first = 1'b0; lock_last = 1'b0;
        for (int i = 0; i < len; i++) begin
            h_sync_in = (i < low) ? 1'b0 : 1'b1;
            tick();
            if (i == 0) lock_first = locked;
            lock_last = locked;
            if (h_active === 1'b1) act_cnt++;
            if (end_line === 1'b1) end_cnt++;
            if (sync_err === 1'b1) begin
                if (err_pos < 0) err_pos = i;
                err_cnt++;
            end
            if (h_active === 1'b1 && x_pos !== 10'(i - 144)) xbad++;
            if (h_active !== 1'b1 && x_pos !== 10'd0) xbad++;
            if (end_line === 1'b1 && (x_pos !== 10'd639 || h_active !== 1'b1)) xbad++;
        end
    endtask

    task automatic test_reset;
        rst_ = 1'b0; enable = 1'b1; h_sync_in = 1'b1;
        #5;
        nchecks++; if (locked !== 1'b0) begin nfail++; $display("FAIL reset_locked: got %b want 0", locked); end
        nchecks++; if (h_active !== 1'b0) begin nfail++; $display("FAIL reset_h_active: got %b want 0", h_active); end
        nchecks++; if (end_line !== 1'b0) begin nfail++; $display("FAIL reset_end_line: got %b want 0", end_line); end
        nchecks++; if (x_pos !== 10'd0) begin nfail++; $display("FAIL reset_x_pos: got %0d want 0", x_pos); end
        nchecks++; if (sync_err !== 1'b0) begin nfail++; $display("FAIL reset_sync_err: got %b want 0", sync_err); end
        tick(); tick();
        rst_ = 1'b1;
        tick();
        nchecks++; if (locked !== 1'b0) begin nfail++; $display("FAIL idle_locked: got %b want 0", locked); end
    endtask

    task automatic test_ideal;
        int errs;
        errs = 0;
        drive_line(800, 96); errs += err_cnt;
        nchecks++; if (lock_first !== 1'b0) begin nfail++; $display("FAIL ideal_lock_fall1: got %b want 0", lock_first); end
        drive_line(800, 96); errs += err_cnt;
        nchecks++; if (lock_first !== 1'b0) begin nfail++; $display("FAIL ideal_lock_fall2: got %b want 0", lock_first); end
        drive_line(800, 96); errs += err_cnt;
        nchecks++; if (lock_first !== 1'b1) begin nfail++; $display("FAIL ideal_lock_fall3: got %b want 1", lock_first); end
        nchecks++; if (act_cnt !== 640) begin nfail++; $display("FAIL ideal_active_cnt: got %0d want 640", act_cnt); end
        nchecks++; if (end_cnt !== 1) begin nfail++; $display("FAIL ideal_end_cnt: got %0d want 1", end_cnt); end
        nchecks++; if (xbad !== 0) begin nfail++; $display("FAIL ideal_x_pos: got %0d bad cycles want 0", xbad); end
        drive_line(800, 96); errs += err_cnt;
        nchecks++; if (act_cnt !== 640 || end_cnt !== 1 || xbad !== 0) begin
            nfail++; $display("FAIL ideal_line4: got act=%0d end=%0d xbad=%0d want 640/1/0", act_cnt, end_cnt, xbad);
        end
        nchecks++; if (errs !== 0) begin nfail++; $display("FAIL ideal_no_err: got %0d pulses want 0", errs); end
    endtask

    task automatic test_short_pulse;
        drive_line(800, 95);
        nchecks++; if (err_pos !== 95 || err_cnt !== 1) begin
            nfail++; $display("FAIL short_err: got pos=%0d cnt=%0d want 95/1", err_pos, err_cnt);
        end
        nchecks++; if (lock_last !== 1'b0) begin nfail++; $display("FAIL short_unlock: got %b want 0", lock_last); end
        drive_line(800, 96);
        nchecks++; if (lock_first !== 1'b0) begin nfail++; $display("FAIL short_restart: got %b want 0", lock_first); end
        drive_line(800, 96);
        nchecks++; if (lock_first !== 1'b0 || err_cnt !== 0) begin
            nfail++; $display("FAIL short_good1: got lock=%b err=%0d want 0/0", lock_first, err_cnt);
        end
        drive_line(800, 96);
        nchecks++; if (lock_first !== 1'b1 || act_cnt !== 640 || err_cnt !== 0) begin
            nfail++; $display("FAIL short_relock: got lock=%b act=%0d err=%0d want 1/640/0", lock_first, act_cnt, err_cnt);
        end
    endtask

    task automatic test_long_line;
        drive_line(801, 96);
        nchecks++; if (err_cnt !== 0 || lock_last !== 1'b1) begin
            nfail++; $display("FAIL long_body: got err=%0d lock=%b want 0/1", err_cnt, lock_last);
        end
        drive_line(800, 96);
        nchecks++; if (err_pos !== 0 || err_cnt !== 1 || lock_first !== 1'b0) begin
            nfail++; $display("FAIL long_late_fall: got pos=%0d cnt=%0d lock=%b want 0/1/0", err_pos, err_cnt, lock_first);
        end
        drive_line(800, 96);
        nchecks++; if (lock_first !== 1'b0 || err_cnt !== 0) begin
            nfail++; $display("FAIL long_good1: got lock=%b err=%0d want 0/0", lock_first, err_cnt);
        end
        drive_line(800, 96);
        nchecks++; if (lock_first !== 1'b1 || err_cnt !== 0) begin
            nfail++; $display("FAIL long_relock: got lock=%b err=%0d want 1/0", lock_first, err_cnt);
        end
    endtask

    task automatic test_enable;
        int frozen_bad;
        int errs;
        errs = 0;
        for (int i = 0; i < 345; i++) begin
            h_sync_in = (i < 96) ? 1'b0 : 1'b1;
            tick();
            if (sync_err === 1'b1) errs++;
        end
        nchecks++; if (x_pos !== 10'd200 || h_active !== 1'b1) begin
            nfail++; $display("FAIL enable_pre: got x=%0d act=%b want 200/1", x_pos, h_active);
        end
        enable = 1'b0;
        frozen_bad = 0;
        repeat (50) begin
            tick();
            if (x_pos !== 10'd200 || h_active !== 1'b1 || locked !== 1'b1 ||
                sync_err !== 1'b0 || end_line !== 1'b0) frozen_bad++;
        end
        nchecks++; if (frozen_bad !== 0) begin nfail++; $display("FAIL enable_hold: got %0d bad cycles want 0", frozen_bad); end
        enable = 1'b1;
        h_sync_in = 1'b1;
        tick();
        nchecks++; if (x_pos !== 10'd201 || h_active !== 1'b1) begin
            nfail++; $display("FAIL enable_resume: got x=%0d act=%b want 201/1", x_pos, h_active);
        end
        for (int i = 346; i < 800; i++) begin
            tick();
            if (sync_err === 1'b1) errs++;
        end
        drive_line(800, 96); errs += err_cnt;
        nchecks++; if (errs !== 0 || lock_first !== 1'b1 || act_cnt !== 640) begin
            nfail++; $display("FAIL enable_after: got err=%0d lock=%b act=%0d want 0/1/640", errs, lock_first, act_cnt);
        end
    endtask

    task automatic test_timeout;
        drive_line(1100, 96);
        nchecks++; if (err_pos !== 1023 || err_cnt !== 1) begin
            nfail++; $display("FAIL timeout_err: got pos=%0d cnt=%0d want 1023/1", err_pos, err_cnt);
        end
        nchecks++; if (lock_last !== 1'b0 || act_cnt !== 640) begin
            nfail++; $display("FAIL timeout_unlock: got lock=%b act=%0d want 0/640", lock_last, act_cnt);
        end
        drive_line(300, 0);
        nchecks++; if (err_cnt !== 0) begin nfail++; $display("FAIL timeout_repeat: got %0d pulses want 0", err_cnt); end
        drive_line(800, 96);
        nchecks++; if (lock_first !== 1'b0 || err_cnt !== 0) begin
            nfail++; $display("FAIL timeout_search_fall: got lock=%b err=%0d want 0/0", lock_first, err_cnt);
        end
        drive_line(800, 96);
        drive_line(800, 96);
        nchecks++; if (lock_first !== 1'b1) begin nfail++; $display("FAIL timeout_relock: got %b want 1", lock_first); end
    endtask

    task automatic test_reset_midline;
        for (int i = 0; i < 445; i++) begin
            h_sync_in = (i < 96) ? 1'b0 : 1'b1;
            tick();
        end
        nchecks++; if (x_pos !== 10'd300) begin nfail++; $display("FAIL rst_pre_x: got %0d want 300", x_pos); end
        #2 rst_ = 1'b0;
        #1;
        nchecks++; if (locked !== 1'b0 || h_active !== 1'b0 || x_pos !== 10'd0 ||
                       end_line !== 1'b0 || sync_err !== 1'b0) begin
            nfail++; $display("FAIL rst_async: got lock=%b act=%b x=%0d end=%b err=%b want all 0",
                              locked, h_active, x_pos, end_line, sync_err);
        end
        tick();
        rst_ = 1'b1;
        drive_line(800, 96);
        nchecks++; if (lock_first !== 1'b0) begin nfail++; $display("FAIL rst_fall1: got %b want 0", lock_first); end
        drive_line(800, 96);
        nchecks++; if (lock_first !== 1'b0) begin nfail++; $display("FAIL rst_fall2: got %b want 0", lock_first); end
        drive_line(800, 96);
        nchecks++; if (lock_first !== 1'b1 || act_cnt !== 640 || err_cnt !== 0) begin
            nfail++; $display("FAIL rst_relock: got lock=%b act=%0d err=%0d want 1/640/0", lock_first, act_cnt, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_short_pulse();
        test_long_line();
        test_enable();
        test_timeout();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule

// File: doc/h_sync_decoder.md
# h_sync_decoder

Receive-side horizontal timing recovery for the VGA display path. The block samples an active-low horizontal sync stream such as the one our horizontal counter drives, and measures sync pulse width and line period against the 640x480@60 horizontal timing. After a programmable number of consecutive good lines it declares lock, then regenerates `h_active`, `end_line` and the active-pixel column `x_pos`. It is used for loopback self-test of the display driver and as the front end of a capture path.

## Interface
- `H_FRONT_PORCH`, default 16: front porch length in pixel clocks.
- `H_SYNC`, default 96: sync pulse width (low) in pixel clocks.
- `H_BACK_PORCH`, default 48: back porch length in pixel clocks.
- `H_ACTIVE`, default 640: active pixels per line.
- `LOCK_LINES`, default 2: consecutive good lines required for lock (1..7).
- `clk` input, 1 bit: pixel clock, 25 MHz. One clock; reset is asynchronous and active-low.
- `rst_` input, 1 bit: asynchronous reset, active low.
- `enable` input, 1 bit: when low, every register holds its value.
- `h_sync_in` input, 1 bit: incoming h sync, active low, synchronous to `clk`.
- `locked` output, 1 bit: timing lock.
- `h_active` output, 1 bit: recovered active-video window. Qualified by `locked`.
- `end_line` output, 1 bit: one-cycle pulse on the last active pixel.
- `x_pos` output, 10 bits: active pixel column 0..639. Reads 0 outside the active window.
- `sync_err` output, 1 bit: one-cycle pulse on any width, period or timeout violation.

## Operation
- Derived constant: H_TOTAL = FP + SYNC + BP + ACTIVE = 800.
- Derived constant: ACT_START = SYNC + BP = 144.
- Derived constant: ACT_END = ACT_START + ACTIVE − 1 = 783.
- Edge detect: `sync_q` is `h_sync_in` registered. Fall = `sync_q` & ~`h_sync_in`. Rise = ~`sync_q` & `h_sync_in`.
- Position counter `pos` is 10 bits:
  - loads 0 on fall;
  - otherwise increments;
  - saturates at 1023.
- Width check on rise: the old `pos` must equal H_SYNC−1 (95). This means exactly 96 low samples.
  - A pass sets internal `width_ok`.
  - A fail clears it.
- Period check on fall: the old `pos` must equal H_TOTAL−1 (799) and `width_ok` must be set.
- The FSM has three states: SEARCH, CHECK and LOCKED.
- SEARCH:
  - On fall, go to CHECK with `good_cnt`=0 and `width_ok`=0.
  - No `sync_err` is raised in this state.
- CHECK:
  - On fall with the period check passing, increment `good_cnt`. When it reaches LOCK_LINES, go to LOCKED.
  - On fall with the period check failing, pulse `sync_err`, clear `good_cnt`, and stay in CHECK. That fall restarts measurement.
  - On rise with the width check failing, pulse `sync_err` and clear `good_cnt`.
- LOCKED:
  - On fall with the period check failing, pulse `sync_err` and go to CHECK with `good_cnt`=0.
  - On rise with the width check failing, pulse `sync_err` and go to CHECK with `good_cnt`=0.
- Timeout: `pos` reaching 1023 in CHECK or LOCKED pulses `sync_err` once and returns the FSM to SEARCH.
- Recovered outputs are registered from `pos_next` and `state_next`, so they are cycle-aligned with `pos`:
  - `h_active` = LOCKED & (ACT_START ≤ pos ≤ ACT_END);
  - `x_pos` = pos − ACT_START while `h_active`, else 0;
  - `end_line` = LOCKED & (pos == ACT_END).
- `locked` equals (state == LOCKED).
- Reset values:
  - state SEARCH;
  - `pos` 0, `sync_q` 1, `good_cnt` 0, `width_ok` 0;
  - `locked`, `h_active`, `end_line`, `x_pos` and `sync_err` all 0.

## Timing
- Convention: fall sampled at edge F, so `pos` = n after edge F+n.
- With ideal input, lock asserts after the edge sampling the (LOCK_LINES+1)th fall. Default: the 3rd fall, i.e. 1600 cycles after the first.
- In the line that begins at lock, `h_active` is high after edges F+144 through F+783, which is 640 cycles.
- Loss-of-lock latency:
  - `sync_err`, `locked` fall and `h_active` fall are all registered on the edge that samples the violating fall or rise;
  - for timeout, on the edge where `pos` becomes 1023.
- Fall and timeout in the same cycle: fall wins. `pos` goes to 0 and no timeout is raised.
- `enable` low: all state, `pos` and outputs freeze. `sync_err` and `end_line` keep their registered value and must not re-pulse while frozen.
- Edges are evaluated only while `enable` is high. `sync_q` also holds while `enable` is low.
- `rst_` low mid-line: all registers take their reset values immediately, independent of `clk`. Recovery needs a full LOCK_LINES+1 falls.

## Test plan
- Ideal 800-cycle lines, 96 low:
  - `locked` rises at the 3rd fall;
  - each following line has exactly 640 `h_active` cycles;
  - `x_pos` runs 0..639;
  - one `end_line` per line, coincident with `x_pos`=639;
  - `sync_err` never pulses.
- While locked, one pulse 95 low: `sync_err` pulses on that rise and `locked` drops. Next fall → CHECK; `locked` returns 2 falls later.
- While locked, one line 801 cycles long: `sync_err` pulses at the late fall; relock after 2 more good lines.
- While locked, hold `h_sync_in` high: at `pos`=1023 there is a single `sync_err` pulse, state returns to SEARCH, and there are no further pulses.
- `enable` low for 50 cycles mid-active at `x_pos`=200: the outputs hold, then resume at 201 with no error.
- Assert `rst_` at `x_pos`=300: all outputs are 0 immediately, and `locked` returns only after 3 falls.
